// File: rtl/step_sequencer_if.sv
// Timer control bus between the step sequencer and the downstream timer.
//   master (sequencer): drives time_count, mode, enable, clear; receives done
//   slave  (timer)    : receives time_count, mode, enable, clear; drives done
interface step_sequencer_if #(
    parameter int TIME_W = 20
);
    logic [TIME_W-1:0] time_count;  // interval loaded into the timer
    logic              mode;        // timer mode (0 = one-shot)
    logic              enable;      // timer run enable
    logic              clear;       // timer clear
    logic              done;        // timer done pulse

    modport master (
        output time_count, mode, enable, clear,
        input  done
    );

    modport slave (
        input  time_count, mode, enable, clear,
        output done
    );
endinterface

// File: rtl/step_sequencer.sv
// Programmable step sequencer feeding a one-shot timer. A table of
// (interval, pattern) entries is walked in order: each step loads its
// interval into the timer, holds its pattern on out_pattern and advances
// on the timer's done pulse. Sequences run once or loop.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_time/wr_pattern
//                         table write port (ignored while busy)
//   cfg_len, cfg_loop     active step count (sampled at start), loop enable
//   start, stop           start request (level), abort request
//   tmr                   timer control bus (master side)
//   out_pattern, step_idx current step pattern and index
//   step_pulse            one-cycle pulse on each step entry
//   busy, seq_done        sequence active, one-cycle completion pulse
module step_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int TIME_W    = 20,
    parameter int OUT_W     = 8,
    localparam int AW       = $clog2(NUM_STEPS),
    localparam int LW       = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [TIME_W-1:0] wr_time,
    input  logic [OUT_W-1:0]  wr_pattern,
    input  logic [LW-1:0]     cfg_len,
    input  logic              cfg_loop,
    input  logic              start,
    input  logic              stop,
    step_sequencer_if.master  tmr,
    output logic [OUT_W-1:0]  out_pattern,
    output logic [AW-1:0]     step_idx,
    output logic              step_pulse,
    output logic              busy,
    output logic              seq_done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [LW-1:0]     len_q, len_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [OUT_W-1:0]  pat_q, pat_d;
    logic              clr_q, clr_d;   // one-cycle timer clear after a stop

    logic [TIME_W-1:0] time_tbl_q [NUM_STEPS];
    logic [TIME_W-1:0] time_tbl_d [NUM_STEPS];
    logic [OUT_W-1:0]  pat_tbl_q  [NUM_STEPS];
    logic [OUT_W-1:0]  pat_tbl_d  [NUM_STEPS];

    logic              addr_ok;
    logic [LW-1:0]     len_clamp;
    logic              last_step;
    logic              load_step;

    // A full power-of-two table makes every address legal; only compare
    // when the address space is larger than the table.
    generate
        if (NUM_STEPS == (1 << AW)) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_cmp
            assign addr_ok = (wr_addr < AW'(NUM_STEPS));
        end
    endgenerate

    always_comb begin
        time_tbl_d = time_tbl_q;
        pat_tbl_d  = pat_tbl_q;
        if (wr_en && (state_q == S_IDLE) && addr_ok) begin
            time_tbl_d[wr_addr] = wr_time;
            pat_tbl_d[wr_addr]  = wr_pattern;
        end
    end

    assign len_clamp = (cfg_len > LW'(NUM_STEPS)) ? LW'(NUM_STEPS) : cfg_len;
    assign last_step = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        time_d    = time_q;
        pat_d     = pat_q;
        clr_d     = 1'b0;
        load_step = 1'b0;

        // stop outranks everything, including a coincident tmr_done
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            pat_d   = '0;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && (len_clamp != '0)) begin
                        state_d   = S_LOAD;
                        idx_d     = '0;
                        len_d     = len_clamp;
                        load_step = 1'b1;
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (tmr.done) begin
                        if (!last_step) begin
                            state_d   = S_LOAD;
                            idx_d     = idx_q + 1'b1;
                            load_step = 1'b1;
                        end else if (cfg_loop) begin
                            state_d   = S_LOAD;
                            idx_d     = '0;
                            load_step = 1'b1;
                        end else begin
                            state_d = S_DONE;
                            idx_d   = '0;
                            pat_d   = '0;
                        end
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Interval and pattern are captured on entry to LOAD so they are
        // already valid during the LOAD cycle and hold until the next one.
        if (load_step) begin
            time_d = time_tbl_q[idx_d];
            pat_d  = pat_tbl_q[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            time_q  <= '0;
            pat_q   <= '0;
            clr_q   <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                time_tbl_q[i] <= '0;
                pat_tbl_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            time_q     <= time_d;
            pat_q      <= pat_d;
            clr_q      <= clr_d;
            time_tbl_q <= time_tbl_d;
            pat_tbl_q  <= pat_tbl_d;
        end
    end

    assign tmr.time_count = time_q;
    assign tmr.mode       = 1'b0;
    assign tmr.enable     = (state_q == S_RUN);
    assign tmr.clear      = (state_q == S_LOAD) || (state_q == S_DONE) || clr_q;
    assign out_pattern    = pat_q;
    assign step_idx       = idx_q;
    assign step_pulse     = (state_q == S_LOAD);
    assign busy           = (state_q != S_IDLE);
    assign seq_done       = (state_q == S_DONE);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer. Expected steps are queued when a
// sequence is started; a negedge monitor pops one entry per step_pulse and
// compares index, interval and pattern. The timer is emulated by driving
// tmr done pulses from the stimulus.
module tb_step_sequencer;

    localparam int NUM_STEPS = 8;
    localparam int TIME_W    = 20;
    localparam int OUT_W     = 8;
    localparam int AW        = $clog2(NUM_STEPS);
    localparam int LW        = AW + 1;

    typedef struct {
        logic [AW-1:0]     idx;
        logic [TIME_W-1:0] t;
        logic [OUT_W-1:0]  p;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [TIME_W-1:0] wr_time = '0;
    logic [OUT_W-1:0]  wr_pattern = '0;
    logic [LW-1:0]     cfg_len = '0;
    logic              cfg_loop = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [OUT_W-1:0]  out_pattern;
    logic [AW-1:0]     step_idx;
    logic              step_pulse;
    logic              busy;
    logic              seq_done;

    step_sequencer_if #(.TIME_W(TIME_W)) tmr_if ();

    step_sequencer #(
        .NUM_STEPS(NUM_STEPS), .TIME_W(TIME_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_time(wr_time), .wr_pattern(wr_pattern),
        .cfg_len(cfg_len), .cfg_loop(cfg_loop), .start(start), .stop(stop),
        .tmr(tmr_if.master),
        .out_pattern(out_pattern), .step_idx(step_idx), .step_pulse(step_pulse),
        .busy(busy), .seq_done(seq_done)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   pulse_cnt = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (step_pulse) begin
            pulse_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL step_pulse_unexpected: idx=%0d time=%0d pat=%0h, expected none",
                       step_idx, tmr_if.time_count, out_pattern);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (step_idx === e.idx && tmr_if.time_count === e.t && out_pattern === e.p)
                else begin
                    errors++;
                    $error("FAIL step_entry: idx=%0d time=%0d pat=%0h, expected idx=%0d time=%0d pat=%0h",
                           step_idx, tmr_if.time_count, out_pattern, e.idx, e.t, e.p);
                end
            end
        end
        if (seq_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_entry(input int a, input int t, input int p);
        wr_en      = 1'b1;
        wr_addr    = AW'(a);
        wr_time    = TIME_W'(t);
        wr_pattern = OUT_W'(p);
        cyc(1);
        wr_en = 1'b0;
    endtask

    task automatic push_exp(input int i, input int t, input int p);
        exp_t e;
        e.idx = AW'(i);
        e.t   = TIME_W'(t);
        e.p   = OUT_W'(p);
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int len, input logic lp);
        cfg_len  = LW'(len);
        cfg_loop = lp;
        start    = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // bounded wait for the timer enable, then check the loaded interval
    task automatic wait_run(input int exp_t_val);
        int n = 0;
        while (!tmr_if.enable && n < 50) begin
            cyc(1);
            n++;
        end
        check("enable_wait", 32'(tmr_if.enable), 32'd1);
        check("run_time", 32'(tmr_if.time_count), 32'(exp_t_val));
    endtask

    task automatic fire_done();
        tmr_if.done = 1'b1;
        cyc(1);
        tmr_if.done = 1'b0;
    endtask

    task automatic run_step(input int exp_t_val);
        wait_run(exp_t_val);
        fire_done();
    endtask

    int p0, d0;

    initial begin
        tmr_if.done = 1'b0;
        #12;
        // reset state
        check("rst_busy", 32'(busy), 0);
        check("rst_enable", 32'(tmr_if.enable), 0);
        check("rst_clear", 32'(tmr_if.clear), 0);
        check("rst_pattern", 32'(out_pattern), 0);
        rst_n = 1'b1;
        cyc(1);

        // 1: one-shot three-step sequence
        write_entry(0, 5, 8'h01);
        write_entry(1, 10, 8'h02);
        write_entry(2, 3, 8'h04);
        push_exp(0, 5, 8'h01); push_exp(1, 10, 8'h02); push_exp(2, 3, 8'h04);
        do_start(3, 1'b0);
        check("t1_step_pulse", 32'(step_pulse), 1);
        check("t1_load_clear", 32'(tmr_if.clear), 1);
        check("t1_load_enable", 32'(tmr_if.enable), 0);
        check("t1_mode", 32'(tmr_if.mode), 0);
        run_step(5);
        run_step(10);
        run_step(3);
        check("t1_seq_done", 32'(seq_done), 1);
        check("t1_done_pattern", 32'(out_pattern), 0);
        check("t1_done_busy", 32'(busy), 1);
        check("t1_done_clear", 32'(tmr_if.clear), 1);
        cyc(1);
        check("t1_idle_busy", 32'(busy), 0);
        check("t1_pulses", 32'(pulse_cnt), 3);
        check("t1_done_cnt", 32'(done_cnt), 1);

        // 2: looping, two full loops then stop during RUN
        p0 = pulse_cnt; d0 = done_cnt;
        for (int i = 0; i < 7; i++) push_exp(i % 3, (i % 3 == 0) ? 5 : (i % 3 == 1) ? 10 : 3, 1 << (i % 3));
        do_start(3, 1'b1);
        for (int i = 0; i < 6; i++) run_step((i % 3 == 0) ? 5 : (i % 3 == 1) ? 10 : 3);
        wait_run(5);
        check("t2_pulses", 32'(pulse_cnt - p0), 7);
        check("t2_no_done", 32'(done_cnt - d0), 0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        check("t2_stop_clear", 32'(tmr_if.clear), 1);
        check("t2_stop_enable", 32'(tmr_if.enable), 0);
        check("t2_stop_pattern", 32'(out_pattern), 0);
        check("t2_stop_busy", 32'(busy), 0);
        check("t2_stop_idx", 32'(step_idx), 0);
        cyc(1);
        check("t2_clear_once", 32'(tmr_if.clear), 0);
        check("t2_stop_no_done", 32'(done_cnt - d0), 0);

        // 3: boundary lengths
        p0 = pulse_cnt;
        cfg_len = '0;
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        check("t3_len0_busy", 32'(busy), 0);
        check("t3_len0_pulse", 32'(pulse_cnt - p0), 0);
        for (int i = 3; i < 8; i++) write_entry(i, 20 + i, 8'h10 + i);
        push_exp(0, 5, 8'h01); push_exp(1, 10, 8'h02); push_exp(2, 3, 8'h04);
        for (int i = 3; i < 8; i++) push_exp(i, 20 + i, 8'h10 + i);
        d0 = done_cnt;
        do_start(15, 1'b0);
        run_step(5); run_step(10); run_step(3);
        for (int i = 3; i < 8; i++) run_step(20 + i);
        check("t3_clamp_done", 32'(seq_done), 1);
        cyc(1);
        check("t3_clamp_pulses", 32'(pulse_cnt - p0), 8);
        check("t3_clamp_done_cnt", 32'(done_cnt - d0), 1);

        // 4: writes while busy are ignored
        push_exp(0, 5, 8'h01); push_exp(1, 10, 8'h02); push_exp(2, 3, 8'h04);
        do_start(3, 1'b0);
        wait_run(5);
        write_entry(1, 99, 8'hFF);
        fire_done();
        run_step(10); run_step(3);
        cyc(1);
        push_exp(0, 5, 8'h01); push_exp(1, 10, 8'h02); push_exp(2, 3, 8'h04);
        do_start(3, 1'b0);
        run_step(5);
        wait_run(10);
        check("t4_rerun_pattern", 32'(out_pattern), 32'h02);
        fire_done();
        run_step(3);
        cyc(1);
        check("t4_queue_empty", 32'(exp_q.size()), 0);

        // 5: stop and tmr_done in the same cycle
        p0 = pulse_cnt; d0 = done_cnt;
        push_exp(0, 5, 8'h01);
        do_start(3, 1'b0);
        wait_run(5);
        stop = 1'b1;
        tmr_if.done = 1'b1;
        cyc(1);
        stop = 1'b0;
        tmr_if.done = 1'b0;
        check("t5_idx", 32'(step_idx), 0);
        check("t5_busy", 32'(busy), 0);
        cyc(3);
        check("t5_pulses", 32'(pulse_cnt - p0), 1);
        check("t5_no_done", 32'(done_cnt - d0), 0);

        // 6: async reset mid-RUN of step 1
        push_exp(0, 5, 8'h01); push_exp(1, 10, 8'h02);
        do_start(3, 1'b0);
        run_step(5);
        wait_run(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_time", 32'(tmr_if.time_count), 0);
        check("t6_rst_enable", 32'(tmr_if.enable), 0);
        check("t6_rst_clear", 32'(tmr_if.clear), 0);
        check("t6_rst_pattern", 32'(out_pattern), 0);
        check("t6_rst_idx", 32'(step_idx), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_pulse", 32'(step_pulse), 0);
        check("t6_rst_done", 32'(seq_done), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        push_exp(0, 0, 8'h00);
        d0 = done_cnt;
        do_start(1, 1'b0);
        check("t6_cleared_time", 32'(tmr_if.time_count), 0);
        check("t6_cleared_pattern", 32'(out_pattern), 0);
        run_step(0);
        check("t6_seq_done", 32'(seq_done), 1);
        cyc(2);
        check("t6_done_cnt", 32'(done_cnt - d0), 1);
        check("final_queue_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Programmable schedule controller that sits directly upstream of the timer and drives its control inputs: time_count, mode, enable and clear.
- Holds a small table of (interval, output pattern) steps.
- Loads each step's interval into the timer, holds that step's pattern on its outputs, and advances when the timer returns a done pulse.
- Used to generate timed multi-phase output sequences, one-shot or looping.

Parameters:
NUM_STEPS, 8, depth of step table (>=2)
TIME_W, 20, width of interval field; matches timer time_count width
OUT_W, 8, width of output pattern per step

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  $clog2(NUM_STEPS)  table write index
wr_time  in  TIME_W  interval in µs for entry
wr_pattern  in  OUT_W  output pattern for entry
cfg_len  in  $clog2(NUM_STEPS)+1  number of active steps
cfg_loop  in  1  1 = restart at step 0 after last step
start  in  1  start request (level sampled per cycle)
stop  in  1  abort request
tmr_time_count  out  TIME_W  interval to timer
tmr_mode  out  1  timer mode; tied 0 (one-shot)
tmr_enable  out  1  timer enable
tmr_clear  out  1  timer clear
tmr_done  in  1  timer done pulse
out_pattern  out  OUT_W  current step pattern
step_idx  out  $clog2(NUM_STEPS)  current step index
step_pulse  out  1  one-cycle pulse on each step entry
busy  out  1  sequence active
seq_done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (async, rst_n=0):
  - Table entries cleared to 0; FSM to IDLE.
  - All outputs 0.
- Table writes:
  - Accepted only when busy=0; a write updates the entry on the next edge.
  - Writes while busy=1 are ignored.
  - wr_addr >= NUM_STEPS is ignored.
- cfg_len:
  - Sampled only when start is accepted; latched internally as len.
  - Values > NUM_STEPS are clamped to NUM_STEPS.
  - len=0 means start is ignored and the FSM stays in IDLE.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - busy=0, tmr_enable=0.
  - start=1 with valid len goes to LOAD with idx=0.
- LOAD (one cycle):
  - tmr_clear=1, tmr_enable=0, busy=1, step_pulse=1.
  - tmr_time_count and out_pattern are registered from table[idx] and remain stable until the next LOAD.
  - Next state: RUN.
- RUN:
  - tmr_enable=1, tmr_clear=0; waits for tmr_done=1.
  - On tmr_done with idx < len-1: idx+1, go to LOAD.
  - On tmr_done with idx = len-1 and cfg_loop=1: idx=0, go to LOAD. cfg_loop is sampled live at this point.
  - On tmr_done with idx = len-1 and cfg_loop=0: go to DONE.
- DONE (one cycle):
  - seq_done=1, tmr_enable=0, tmr_clear=1.
  - out_pattern cleared to 0, idx=0.
  - Next state: IDLE; busy drops on the cycle after DONE.
- Latency:
  - start accepted at edge N: step_pulse is high in cycle N+1 and tmr_enable rises in cycle N+2.
  - tmr_done sampled at edge M: next step_pulse is in cycle M+1.
- stop:
  - Highest priority, in any non-IDLE state.
  - Next edge: IDLE, tmr_clear=1 for one cycle, tmr_enable=0, out_pattern=0, idx=0.
  - No seq_done is issued.
- Simultaneous events:
  - stop together with tmr_done: stop wins and there is no advance.
  - start while busy: ignored.
  - tmr_done outside RUN: ignored.
- Interval of 0 is legal; the step duration is then the timer's minimum latency.
- The block makes no assumption on timer latency; it advances only on tmr_done.

Test Plan:
1. Program steps (5,0x01),(10,0x02),(3,0x04); cfg_len=3, cfg_loop=0; pulse start.
   Required: tmr_time_count takes 5, 10, 3 in order; out_pattern takes 0x01, 0x02, 0x04; exactly 3 step_pulses; one seq_done after the third tmr_done; out_pattern=0 and busy=0 afterwards.
2. Same table with cfg_loop=1, run 2 full loops.
   Required: step_idx sequence 0,1,2,0,1,2,0; no seq_done.
   Then assert stop during RUN. Required: next cycle tmr_clear=1, tmr_enable=0, out_pattern=0, busy=0.
3. Boundary lengths: cfg_len=0 with start leaves busy=0 and no step_pulse. cfg_len=15 with NUM_STEPS=8 runs 8 steps then seq_done.
4. While busy, write entry 1 to (99,0xFF) and let the sequence finish. Required: the running sequence is unaffected; a rerun shows the old value (10,0x02).
5. Same-cycle event: assert stop in the same cycle as tmr_done on step 0. Required: no step_pulse, step_idx=0, no seq_done.
6. Reset mid-operation: assert rst_n=0 mid-RUN of step 1. Required: all outputs 0 immediately (async); table cleared; after release, start with cfg_len=1 yields interval 0 and pattern 0x00.
